// File: rtl/data_arith_multiply_pkg.sv
// Shared types for the execute-path multiplier.
//   Data_Control_T              : clock + active-low synchronous reset bundle
//   Data_Arith_SignedUnsigned_T : operand interpretation selector
package data_arith_multiply_pkg;

  typedef struct packed {
    logic clk;    // single clock, rising edge
    logic rst_n;  // synchronous, active-low (0 = reset)
  } Data_Control_T;

  typedef enum logic {
    SIGN_UNSIGNED = 1'b0,
    SIGN_SIGNED   = 1'b1
  } Data_Arith_SignedUnsigned_T;

endpackage

// File: rtl/data_arith_multiply.sv
// Iterative radix-2 shift-add multiplier (W cycles per product).
// Signed operands are reduced to magnitudes on acceptance and the sign is
// re-applied to the 2W-bit result on the final iteration.
//
// Ports:
//   ctrl      in  : clock / synchronous active-low reset bundle
//   in_valid  in  : operand pair a/b/sign is valid
//   in_ready  out : block can accept operands (IDLE only)
//   a, b      in  : multiplicand, multiplier (W bits)
//   sign      in  : signed or unsigned interpretation of a and b
//   out_valid out : hi/lo hold a finished product (DONE)
//   out_ready in  : consumer accepts the product
//   hi, lo    out : product bits [2W-1:W] and [W-1:0]
//   busy      out : high in RUN or DONE
module data_arith_multiply
  import data_arith_multiply_pkg::*;
#(
  parameter int W = 8
) (
  input  Data_Control_T              ctrl,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [W-1:0]               a,
  input  logic [W-1:0]               b,
  input  Data_Arith_SignedUnsigned_T sign,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [W-1:0]               hi,
  output logic [W-1:0]               lo,
  output logic                       busy
);

  localparam int CNT_W = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  logic clk;
  logic rst_n;
  assign clk   = ctrl.clk;
  assign rst_n = ctrl.rst_n;

  state_t state_reg, state_next;

  logic [W-1:0]     mcand_reg;
  logic [W-1:0]     mplier_reg;
  logic [W:0]       acc_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             neg_reg;
  logic [W-1:0]     hi_reg;
  logic [W-1:0]     lo_reg;

  logic             accept;
  logic             last_iter;
  logic [W-1:0]     mag_a;
  logic [W-1:0]     mag_b;
  logic [W:0]       sum;
  logic [W-1:0]     acc_shift;
  logic [W-1:0]     mplier_shift;
  logic [2*W-1:0]   product;
  logic [2*W-1:0]   result;

  assign accept    = (state_reg == IDLE) && in_valid;
  assign last_iter = (cnt_reg == CNT_W'(W - 1));

  // Two's-complement magnitude; -2^(W-1) maps to 2^(W-1), which still fits
  // in W unsigned bits.
  assign mag_a = (sign == SIGN_SIGNED && a[W-1]) ? (~a + 1'b1) : a;
  assign mag_b = (sign == SIGN_SIGNED && b[W-1]) ? (~b + 1'b1) : b;

  // One shift-add step. The accumulator stays below 2^W after each shift, so
  // the W+1-bit sum never overflows.
  always_comb begin
    sum          = acc_reg + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
    acc_shift    = sum[W:1];
    mplier_shift = {sum[0], mplier_reg[W-1:1]};
    product      = {acc_shift, mplier_shift};
    result       = neg_reg ? (~product + 1'b1) : product;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM next-state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      neg_reg    <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
    end else if (accept) begin
      mcand_reg  <= mag_a;
      mplier_reg <= mag_b;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      neg_reg    <= (sign == SIGN_SIGNED) && (a[W-1] ^ b[W-1]);
    end else if (state_reg == RUN) begin
      acc_reg    <= {1'b0, acc_shift};
      mplier_reg <= mplier_shift;
      cnt_reg    <= cnt_reg + 1'b1;
      // hi/lo only move here, so the last product stays visible until the
      // next one completes.
      if (last_iter) begin
        hi_reg <= result[2*W-1:W];
        lo_reg <= result[W-1:0];
      end
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg != IDLE);
  assign hi        = hi_reg;
  assign lo        = lo_reg;

endmodule

// File: tb/tb_data_arith_multiply.sv
module tb_data_arith_multiply;
  import data_arith_multiply_pkg::*;

  localparam int W = 8;

  logic                       clk;
  logic                       rst_n;
  Data_Control_T              ctrl;
  logic                       in_valid;
  logic                       in_ready;
  logic [W-1:0]               a;
  logic [W-1:0]               b;
  Data_Arith_SignedUnsigned_T sign;
  logic                       out_valid;
  logic                       out_ready;
  logic [W-1:0]               hi;
  logic [W-1:0]               lo;
  logic                       busy;

  int checks = 0;
  int errors = 0;

  assign ctrl = {clk, rst_n};

  data_arith_multiply #(.W(W)) dut (
    .ctrl      (ctrl),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hi        (hi),
    .lo        (lo),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer multiplication of the interpreted operands.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input bit is_signed);
    int sx, sy, p;
    sx = is_signed ? int'($signed(x)) : int'(x);
    sy = is_signed ? int'($signed(y)) : int'(y);
    p  = sx * sy;
    return p[2*W-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction: accept, W run cycles with scrambled inputs,
  // `stall` cycles of backpressure in DONE, then release.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                        input Data_Arith_SignedUnsigned_T ts, input int stall);
    logic [2*W-1:0] exp;
    int waited;
    exp = ref_mul(ta, tb_, ts == SIGN_SIGNED);
    waited = 0;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    a = ta; b = tb_; sign = ts; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= W; k++) begin
      check("run_out_valid", 32'(out_valid), 32'd0);
      check("run_in_ready", 32'(in_ready), 32'd0);
      check("run_busy", 32'(busy), 32'd1);
      a = W'($urandom); b = W'($urandom);
      sign = ($urandom_range(0, 1) != 0) ? SIGN_SIGNED : SIGN_UNSIGNED;
      in_valid = ($urandom_range(0, 1) != 0);
      tick();
    end
    in_valid = 1'b0;
    check("done_out_valid", 32'(out_valid), 32'd1);
    check("done_hi", 32'(hi), 32'(exp[2*W-1:W]));
    check("done_lo", 32'(lo), 32'(exp[W-1:0]));
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_hi", 32'(hi), 32'(exp[2*W-1:W]));
      check("stall_lo", 32'(lo), 32'(exp[W-1:0]));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_out_valid", 32'(out_valid), 32'd0);
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_busy", 32'(busy), 32'd0);
    $display("op a=%02h b=%02h signed=%0d -> hi=%02h lo=%02h (expect %04h) stall=%0d",
             ta, tb_, ts == SIGN_SIGNED, hi, lo, exp, stall);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sign = SIGN_UNSIGNED;
    tick();
    tick();
    rst_n = 1'b1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_hi", 32'(hi), 32'd0);
    check("reset_lo", 32'(lo), 32'd0);

    // Directed cases
    run_op(8'h7F, 8'h02, SIGN_SIGNED, 0);
    run_op(8'hFB, 8'h03, SIGN_SIGNED, 0);
    run_op(8'hFB, 8'h03, SIGN_UNSIGNED, 0);
    run_op(8'hFF, 8'hFF, SIGN_UNSIGNED, 0);
    run_op(8'hFF, 8'hFF, SIGN_SIGNED, 0);
    run_op(8'h80, 8'h80, SIGN_SIGNED, 5);
    run_op(8'h00, 8'h85, SIGN_SIGNED, 1);
    run_op(8'h02, 8'h03, SIGN_UNSIGNED, 0);

    // Reset in the middle of a run
    a = 8'h7F; b = 8'h7F; sign = SIGN_SIGNED; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset_in_ready", 32'(in_ready), 32'd1);
    check("midreset_out_valid", 32'(out_valid), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_hi", 32'(hi), 32'd0);
    check("midreset_lo", 32'(lo), 32'd0);
    $display("reset mid-run: hi=%02h lo=%02h busy=%0d", hi, lo, busy);
    run_op(8'h03, 8'h04, SIGN_UNSIGNED, 0);

    // Randomised operations against the reference
    for (int i = 0; i < 24; i++) begin
      run_op(W'($urandom), W'($urandom),
             ($urandom_range(0, 1) != 0) ? SIGN_SIGNED : SIGN_UNSIGNED,
             int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
